interrupt_sequencer: RTL and testbench
======================================

# interrupt_sequencer

Front-end interrupt sequencer feeding the five-stage pipeline's fetch and memory stages. It latches an external interrupt request and waits for a safe point, where there is no stall and no taken branch or jump. It then freezes fetch and drives three stack pushes into the memory stage: PC low word, PC high word, then CCR. Finally it redirects fetch to a fixed ISR vector and blocks further interrupts until return-from-interrupt completes. It provides the "int signal" and 2-bit "counter value" inputs of the memory stage, which are currently tied to constants.

## Interface
- VECTOR_ADDR, 32'h0000_0020: ISR entry address loaded into PC.
- PC_W, 32: program-counter width.
- DATA_W, 16: stack word width.
- CCR_W, 3: flag register width.

Ports:
- clk  in  1: rising-edge clock.
- reset  in  1: asynchronous, active-low reset; all state cleared while low.
- int_req  in  1: external interrupt request, level input, edge-detected internally.
- stall  in  1: HDU stall (fetch/decode register disabled); holds the sequencer in its current state.
- flush  in  1: branch taken or unconditional jump in execute; defers a start from IDLE.
- rti_done  in  1: one-cycle pulse when RTI has restored PC and CCR in write-back.
- pc_in  in  PC_W: address of the next instruction to resume.
- ccr_in  in  CCR_W: current flag register.
- int_active  out  1: memory-stage int signal, high in PUSH_PC_LO, PUSH_PC_HI and PUSH_CCR.
- int_count  out  2: memory-stage counter value; 0, 1, 2 across the three pushes, 0 otherwise.
- push_data  out  DATA_W: word to push onto the stack.
- fetch_freeze  out  1: high from PUSH_PC_LO through LOAD_VEC inclusive.
- pc_load  out  1: one-cycle PC override strobe.
- pc_load_addr  out  PC_W: equals VECTOR_ADDR when pc_load is high, 0 otherwise.
- in_isr  out  1: high from LOAD_VEC until rti_done is accepted.

## Operation
- Edge detect: `pending` is set on the clock edge where int_req=1 and its registered copy is 0. It is cleared on entry to PUSH_PC_LO. A new edge arriving while pending is already set is absorbed, so nesting depth is 1.
- Saved PC: `pc_save` captures pc_in on the IDLE→PUSH_PC_LO transition. `ccr_save` captures ccr_in on the same edge.
- States: IDLE, PUSH_PC_LO, PUSH_PC_HI, PUSH_CCR, LOAD_VEC, IN_ISR.
- IDLE → PUSH_PC_LO when pending & !stall & !flush. Otherwise stay in IDLE.
- PUSH_PC_LO → PUSH_PC_HI → PUSH_CCR → LOAD_VEC advance one step per cycle when !stall. When stall is high, the state and all outputs hold.
- LOAD_VEC → IN_ISR unconditionally, since a PC load cannot be stalled.
- IN_ISR → IDLE when rti_done is high. rti_done in any other state is ignored.
- push_data per state:
  - PUSH_PC_LO: pc_save[15:0].
  - PUSH_PC_HI: pc_save[31:16].
  - PUSH_CCR: {13'b0, ccr_save}.
  - All other states: 0.
- All outputs are Moore-registered, decoded from state and the saved registers.
- Simultaneous events:
  - int edge and rti_done in the same cycle: the sequencer returns to IDLE with pending set and starts again next cycle if eligible.
  - stall and flush together in IDLE: no start.
  - int edge while in IN_ISR: becomes pending and is serviced after return.

## Timing
- Reset (reset=0): state=IDLE, pending=0, pc_save=0, ccr_save=0, edge register=0. All outputs are 0.
- Latency: int_req rises before edge N, so pending=1 after edge N. If eligible, state=PUSH_PC_LO after edge N+1. The three push cycles follow, pc_load is high on the fifth cycle after edge N, and there are 5 cycles from the request edge to the vector load.
- Each stall cycle during the pushes adds exactly one cycle.
- Reset asserted mid-sequence returns the block to IDLE immediately. The partial push is abandoned and not resumed.
- The 32-bit PC splits into [15:0] then [31:16], with no arithmetic; the CCR is zero-extended.

## Structure
- Shared processor_pkg holds:
  - the state enum (3-bit encoding);
  - VECTOR_ADDR default;
  - DATA_W, PC_W and CCR_W constants.
- Sub-module int_edge_latch contains the edge detector and the pending flag, with a clear input driven by IDLE→PUSH_PC_LO.
- The FSM and output decode stay in interrupt_sequencer.

## Test plan
- Single interrupt: pc_in=32'h0001_2345, ccr_in=3'b101, int_req rises.
  - Required: push_data 16'h2345, 16'h0001, 16'h0005 on consecutive cycles with int_count 0, 1, 2.
  - Required: pc_load=1 with pc_load_addr=32'h0000_0020 on the next cycle, then in_isr=1.
- Deferral: int_req rises while flush=1 for 2 cycles. Required: PUSH_PC_LO is entered only on the first cycle after flush drops, and the saved pc_in is the value at that time.
- Stall mid-sequence: stall=1 for 3 cycles during PUSH_PC_HI. Required: push_data holds 16'h0001 and int_count holds 1 for 3 extra cycles, and the total sequence is 7 cycles.
- Nested request: a second int_req edge arrives while in IN_ISR. Required: no push occurs. After the rti_done pulse, the state is IDLE for one cycle, then a full second sequence runs.
- Reset mid-sequence: reset=0 while in PUSH_CCR. Required: all outputs are 0 immediately (asynchronously), and after reset=1 the state is IDLE with pending=0.
- Level-held request: int_req held high for 20 cycles. Required: exactly one sequence runs.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared processor definitions: datapath widths, the interrupt vector and the
// interrupt sequencer state encoding.
package processor_pkg;

   localparam int unsigned PC_W   = 32;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CCR_W  = 3;

   localparam logic [PC_W-1:0] DEFAULT_VECTOR_ADDR = 32'h0000_0020;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StPushPcLo = 3'd1,
      StPushPcHi = 3'd2,
      StPushCcr  = 3'd3,
      StLoadVec  = 3'd4,
      StInIsr    = 3'd5
   } int_seq_state_e;

endpackage

// File: rtl/int_edge_latch.sv
// Rising-edge detector on the interrupt request with a single-deep pending flag.
module int_edge_latch (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req_i,
   input  logic clear_i,
   output logic pending_o
);

   logic req_q;
   logic pending_q, pending_d;

   // Clear wins: it only fires while pending is already set, so a
   // coincident edge is absorbed.
   always_comb begin
      pending_d = pending_q;
      if (clear_i) begin
         pending_d = 1'b0;
      end else if (req_i && !req_q) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_q     <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         req_q     <= req_i;
         pending_q <= pending_d;
      end
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: waits for a safe point, pushes PC and CCR to the
// stack through the memory stage, then redirects fetch to the ISR vector.
module interrupt_sequencer
   import processor_pkg::*;
#(
   parameter logic [PC_W-1:0] VECTOR_ADDR = DEFAULT_VECTOR_ADDR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              int_req,
   input  logic              stall,
   input  logic              flush,
   input  logic              rti_done,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [CCR_W-1:0]  ccr_in,
   output logic              int_active,
   output logic [1:0]        int_count,
   output logic [DATA_W-1:0] push_data,
   output logic              fetch_freeze,
   output logic              pc_load,
   output logic [PC_W-1:0]   pc_load_addr,
   output logic              in_isr
);

   int_seq_state_e   state_q, state_d;
   logic             pending;
   logic             start;
   logic [PC_W-1:0]  pc_save_q;
   logic [CCR_W-1:0] ccr_save_q;

   assign start = (state_q == StIdle) && pending && !stall && !flush;

   int_edge_latch u_edge_latch (
      .clk_i     (clk),
      .rst_ni    (reset),
      .req_i     (int_req),
      .clear_i   (start),
      .pending_o (pending)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (start)    state_d = StPushPcLo;
         StPushPcLo: if (!stall)   state_d = StPushPcHi;
         StPushPcHi: if (!stall)   state_d = StPushCcr;
         StPushCcr:  if (!stall)   state_d = StLoadVec;
         // The PC override cannot be held off, so stall is ignored here.
         StLoadVec:                state_d = StInIsr;
         StInIsr:    if (rti_done) state_d = StIdle;
         default:                  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         pc_save_q  <= '0;
         ccr_save_q <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            pc_save_q  <= pc_in;
            ccr_save_q <= ccr_in;
         end
      end
   end

   always_comb begin
      int_active   = 1'b0;
      int_count    = 2'd0;
      push_data    = '0;
      fetch_freeze = 1'b0;
      pc_load      = 1'b0;
      pc_load_addr = '0;
      in_isr       = 1'b0;
      unique case (state_q)
         StPushPcLo: begin
            int_active   = 1'b1;
            int_count    = 2'd0;
            push_data    = pc_save_q[15:0];
            fetch_freeze = 1'b1;
         end
         StPushPcHi: begin
            int_active   = 1'b1;
            int_count    = 2'd1;
            push_data    = pc_save_q[31:16];
            fetch_freeze = 1'b1;
         end
         StPushCcr: begin
            int_active   = 1'b1;
            int_count    = 2'd2;
            push_data    = {{(DATA_W-CCR_W){1'b0}}, ccr_save_q};
            fetch_freeze = 1'b1;
         end
         StLoadVec: begin
            fetch_freeze = 1'b1;
            pc_load      = 1'b1;
            pc_load_addr = VECTOR_ADDR;
            in_isr       = 1'b1;
         end
         StInIsr: in_isr = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed-vector bench for interrupt_sequencer.
module tb_interrupt_sequencer;

   logic        clk;
   logic        reset;
   logic        int_req;
   logic        stall;
   logic        flush;
   logic        rti_done;
   logic [31:0] pc_in;
   logic [2:0]  ccr_in;
   logic        int_active;
   logic [1:0]  int_count;
   logic [15:0] push_data;
   logic        fetch_freeze;
   logic        pc_load;
   logic [31:0] pc_load_addr;
   logic        in_isr;

   int checks;
   int errors;

   interrupt_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .int_req      (int_req),
      .stall        (stall),
      .flush        (flush),
      .rti_done     (rti_done),
      .pc_in        (pc_in),
      .ccr_in       (ccr_in),
      .int_active   (int_active),
      .int_count    (int_count),
      .push_data    (push_data),
      .fetch_freeze (fetch_freeze),
      .pc_load      (pc_load),
      .pc_load_addr (pc_load_addr),
      .in_isr       (in_isr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {int_active, int_count, push_data, fetch_freeze, pc_load, pc_load_addr, in_isr}
   logic [53:0] obs;
   assign obs = {int_active, int_count, push_data, fetch_freeze, pc_load, pc_load_addr, in_isr};

   function automatic logic [53:0] pk(input logic a, input logic [1:0] c, input logic [15:0] d,
                                      input logic f, input logic l, input logic [31:0] ad,
                                      input logic i);
      return {a, c, d, f, l, ad, i};
   endfunction

   localparam logic [53:0] ZERO_V = '0;
   localparam logic [53:0] LOAD_V = {1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 32'h0000_0020, 1'b1};
   localparam logic [53:0] ISR_V  = {1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; int_req = 1'b0; stall = 1'b0; flush = 1'b0; rti_done = 1'b0;
      pc_in = 32'h0; ccr_in = 3'b0;
      #2;
      checks++;
      if (obs !== ZERO_V) begin
         errors++;
         $display("FAIL reset_low: got %h want %h", obs, ZERO_V);
      end
      tick();
      tick();
      reset = 1'b1;
      tick();
      checks++;
      if (obs !== ZERO_V) begin
         errors++;
         $display("FAIL reset_release: got %h want %h", obs, ZERO_V);
      end
   endtask

   task automatic test_single();
      logic [53:0] exp [0:5];
      exp[0] = ZERO_V;
      exp[1] = pk(1'b1, 2'd0, 16'h2345, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[2] = pk(1'b1, 2'd1, 16'h0001, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[3] = pk(1'b1, 2'd2, 16'h0005, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[4] = LOAD_V;
      exp[5] = ISR_V;
      pc_in = 32'h0001_2345; ccr_in = 3'b101; int_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL single step %0d: got %h want %h", i, obs, exp[i]);
         end
         // Saved copies must be used, not the live inputs.
         if (i == 1) begin
            pc_in = 32'hFFFF_FFFF; ccr_in = 3'b000;
         end
      end
      int_req = 1'b0; rti_done = 1'b1;
      tick();
      rti_done = 1'b0;
      checks++;
      if (obs !== ZERO_V) begin
         errors++;
         $display("FAIL single_return: got %h want %h", obs, ZERO_V);
      end
   endtask

   task automatic test_deferral();
      logic [53:0] exp [0:6];
      exp[0] = ZERO_V;
      exp[1] = ZERO_V;
      exp[2] = pk(1'b1, 2'd0, 16'h1234, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[3] = pk(1'b1, 2'd1, 16'hABCD, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[4] = pk(1'b1, 2'd2, 16'h0003, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[5] = LOAD_V;
      exp[6] = ISR_V;
      flush = 1'b1; int_req = 1'b1; pc_in = 32'h1111_2222; ccr_in = 3'b010;
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL deferral step %0d: got %h want %h", i, obs, exp[i]);
         end
         if (i == 0) pc_in = 32'hABCD_1234;
         if (i == 1) begin
            flush = 1'b0; ccr_in = 3'b011;
         end
      end
      int_req = 1'b0; rti_done = 1'b1;
      tick();
      rti_done = 1'b0;
      checks++;
      if (obs !== ZERO_V) begin
         errors++;
         $display("FAIL deferral_return: got %h want %h", obs, ZERO_V);
      end
   endtask

   task automatic test_idle_hold();
      logic [53:0] exp [0:6];
      exp[0] = ZERO_V;
      exp[1] = ZERO_V;
      exp[2] = pk(1'b1, 2'd0, 16'hBEEF, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[3] = pk(1'b1, 2'd1, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[4] = pk(1'b1, 2'd2, 16'h0007, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[5] = LOAD_V;
      exp[6] = ISR_V;
      // rti_done in IDLE must be ignored; stall+flush together block the start.
      stall = 1'b1; flush = 1'b1; rti_done = 1'b1; int_req = 1'b1;
      pc_in = 32'h0000_BEEF; ccr_in = 3'b111;
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL idle_hold step %0d: got %h want %h", i, obs, exp[i]);
         end
         if (i == 1) begin
            stall = 1'b0; flush = 1'b0; rti_done = 1'b0;
         end
      end
      int_req = 1'b0; rti_done = 1'b1;
      tick();
      rti_done = 1'b0;
      checks++;
      if (obs !== ZERO_V) begin
         errors++;
         $display("FAIL idle_hold_return: got %h want %h", obs, ZERO_V);
      end
   endtask

   task automatic test_stall();
      logic [53:0] exp [0:8];
      int          freeze_cycles;
      logic [53:0] hi_v;
      hi_v   = pk(1'b1, 2'd1, 16'h0001, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[0] = ZERO_V;
      exp[1] = pk(1'b1, 2'd0, 16'h2345, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[2] = hi_v;
      exp[3] = hi_v;
      exp[4] = hi_v;
      exp[5] = hi_v;
      exp[6] = pk(1'b1, 2'd2, 16'h0005, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[7] = LOAD_V;
      exp[8] = ISR_V;
      freeze_cycles = 0;
      pc_in = 32'h0001_2345; ccr_in = 3'b101; int_req = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (fetch_freeze) freeze_cycles++;
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL stall step %0d: got %h want %h", i, obs, exp[i]);
         end
         if (i == 2) stall = 1'b1;
         if (i == 5) stall = 1'b0;
      end
      checks++;
      if (freeze_cycles !== 7) begin
         errors++;
         $display("FAIL stall_length: got %0d cycles want 7", freeze_cycles);
      end
      int_req = 1'b0; rti_done = 1'b1;
      tick();
      rti_done = 1'b0;
   endtask

   task automatic test_nested();
      logic [53:0] exp [0:14];
      exp[0]  = ZERO_V;
      exp[1]  = pk(1'b1, 2'd0, 16'h0004, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[2]  = pk(1'b1, 2'd1, 16'h0002, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[3]  = pk(1'b1, 2'd2, 16'h0001, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[4]  = LOAD_V;
      exp[5]  = ISR_V;
      exp[6]  = ISR_V;
      exp[7]  = ISR_V;
      exp[8]  = ISR_V;
      exp[9]  = ZERO_V;
      exp[10] = pk(1'b1, 2'd0, 16'h0005, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[11] = pk(1'b1, 2'd1, 16'h0003, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[12] = pk(1'b1, 2'd2, 16'h0006, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[13] = LOAD_V;
      exp[14] = ISR_V;
      pc_in = 32'h0002_0004; ccr_in = 3'b001; int_req = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL nested step %0d: got %h want %h", i, obs, exp[i]);
         end
         if (i == 5) int_req = 1'b0;
         if (i == 6) begin
            int_req = 1'b1; pc_in = 32'h0003_0005; ccr_in = 3'b110;
         end
         if (i == 8) rti_done = 1'b1;
         if (i == 9) rti_done = 1'b0;
      end
      int_req = 1'b0; rti_done = 1'b1;
      tick();
      rti_done = 1'b0;
   endtask

   task automatic test_edge_rti();
      logic [53:0] exp [0:12];
      exp[0]  = ZERO_V;
      exp[1]  = pk(1'b1, 2'd0, 16'h0010, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[2]  = pk(1'b1, 2'd1, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[3]  = pk(1'b1, 2'd2, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[4]  = LOAD_V;
      exp[5]  = ISR_V;
      exp[6]  = ISR_V;
      exp[7]  = ZERO_V;
      exp[8]  = pk(1'b1, 2'd0, 16'h0010, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[9]  = pk(1'b1, 2'd1, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[10] = pk(1'b1, 2'd2, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[11] = LOAD_V;
      exp[12] = ISR_V;
      pc_in = 32'h0000_0010; ccr_in = 3'b000; int_req = 1'b1;
      for (int i = 0; i < 13; i++) begin
         tick();
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL edge_rti step %0d: got %h want %h", i, obs, exp[i]);
         end
         if (i == 5) int_req = 1'b0;
         if (i == 6) begin
            int_req = 1'b1; rti_done = 1'b1;
         end
         if (i == 7) rti_done = 1'b0;
      end
      int_req = 1'b0; rti_done = 1'b1;
      tick();
      rti_done = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [53:0] exp [0:3];
      exp[0] = ZERO_V;
      exp[1] = pk(1'b1, 2'd0, 16'h2345, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[2] = pk(1'b1, 2'd1, 16'h0001, 1'b1, 1'b0, 32'h0, 1'b0);
      exp[3] = pk(1'b1, 2'd2, 16'h0005, 1'b1, 1'b0, 32'h0, 1'b0);
      pc_in = 32'h0001_2345; ccr_in = 3'b101; int_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL reset_mid step %0d: got %h want %h", i, obs, exp[i]);
         end
      end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (obs !== ZERO_V) begin
         errors++;
         $display("FAIL reset_async: got %h want %h", obs, ZERO_V);
      end
      int_req = 1'b0;
      tick();
      reset = 1'b1;
      // A surviving pending flag or state would start a sequence within one cycle.
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (obs !== ZERO_V) begin
            errors++;
            $display("FAIL reset_mid_idle cycle %0d: got %h want %h", i, obs, ZERO_V);
         end
      end
   endtask

   task automatic test_level();
      int loads;
      int actives;
      loads = 0; actives = 0;
      pc_in = 32'h0000_0100; ccr_in = 3'b010; int_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (pc_load) loads++;
         if (int_active) actives++;
         if (i == 8) rti_done = 1'b1;
         if (i == 9) rti_done = 1'b0;
      end
      checks++;
      if (loads !== 1) begin
         errors++;
         $display("FAIL level_loads: got %0d want 1", loads);
      end
      checks++;
      if (actives !== 3) begin
         errors++;
         $display("FAIL level_pushes: got %0d want 3", actives);
      end
      checks++;
      if (obs !== ZERO_V) begin
         errors++;
         $display("FAIL level_final: got %h want %h", obs, ZERO_V);
      end
      int_req = 1'b0;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_deferral();
      test_idle_hold();
      test_stall();
      test_nested();
      test_edge_rti();
      test_reset_mid();
      test_level();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
